// File: rtl/exec_mem_unit.sv
// exec_mem_unit: LEGv8 execute/memory stage with ALU-control decode, 64-bit ALU and doubleword data memory
module exec_mem_unit #(
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_op1,
    input  logic        alu_op0,
    input  logic [10:0] opcode,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    input  logic [63:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] alu_result,
    output logic        zero,
    output logic [63:0] read_data
);
    logic [63:0]   mem_q [DEPTH];
    logic [3:0]    rtype_ctrl;
    logic [AW-1:0] idx;
    logic          unused_addr;

    always_comb begin
        rtype_ctrl = (opcode == 11'b11001011000) ? 4'b0110 :
                     (opcode == 11'b10001010000) ? 4'b0000 :
                     (opcode == 11'b10101010000) ? 4'b0001 : 4'b0010;
        alu_ctrl   = alu_op1 ? rtype_ctrl : alu_op0 ? 4'b0111 : 4'b0010;
    end

    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = operand_a & operand_b;
            4'b0001: alu_result = operand_a | operand_b;
            4'b0010: alu_result = operand_a + operand_b;
            4'b0110: alu_result = operand_a - operand_b;
            4'b0111: alu_result = operand_b;
            4'b1100: alu_result = ~(operand_a | operand_b);
            default: alu_result = 64'd0;
        endcase
        zero = (alu_result == 64'd0);
    end

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign idx         = alu_result[AW+2:3];
    assign unused_addr = ^{alu_result[2:0], alu_result[63:AW+3]};
    assign read_data   = mem_read ? mem_q[idx] : 64'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'd0;
        end else if (mem_write) begin
            mem_q[idx] <= write_data;
        end
    end
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: table-driven ALU/decoder vectors plus directed memory and reset sequences
module tb_exec_mem_unit;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset, alu_op1, alu_op0, mem_read, mem_write;
    logic [10:0] opcode;
    logic [63:0] operand_a, operand_b, write_data;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result, read_data;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [10:0] opc;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  ctrl;
        logic [63:0] res;
        logic        z;
    } vec_t;

    vec_t vecs [10];

    exec_mem_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .alu_op1(alu_op1), .alu_op0(alu_op0),
        .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero), .read_data(read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_addr(input logic [63:0] a, input logic [63:0] b);
        alu_op1 = 1'b0; alu_op0 = 1'b0; operand_a = a; operand_b = b;
    endtask

    initial begin
        vecs[0] = '{2'b10, 11'b10001011000, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0};
        vecs[1] = '{2'b10, 11'b11001011000, 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1};
        vecs[2] = '{2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 4'b0000, 64'h00F0, 1'b0};
        vecs[3] = '{2'b10, 11'b10101010000, 64'hF0F0, 64'h0FF0, 4'b0001, 64'hFFF0, 1'b0};
        vecs[4] = '{2'b10, 11'b11111000010, 64'hF0F0, 64'h0FF0, 4'b0010, 64'h100E0, 1'b0};
        vecs[5] = '{2'b01, 11'b11001011000, 64'd123, 64'd0, 4'b0111, 64'd0, 1'b1};
        vecs[6] = '{2'b01, 11'b10001010000, 64'd123, 64'd4, 4'b0111, 64'd4, 1'b0};
        vecs[7] = '{2'b00, 11'b11001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1};
        vecs[8] = '{2'b11, 11'b11001011000, 64'd10, 64'd3, 4'b0110, 64'd7, 1'b0};
        vecs[9] = '{2'b10, 11'b11001011000, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        reset = 1'b1; alu_op1 = 1'b0; alu_op0 = 1'b0; opcode = '0;
        operand_a = '0; operand_b = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        mem_read = 1'b1;
        set_addr(64'h18, 64'h0);
        #1 check("reset_read", read_data, 64'd0);
        mem_read = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            {alu_op1, alu_op0} = vecs[i].op;
            opcode = vecs[i].opc; operand_a = vecs[i].a; operand_b = vecs[i].b;
            #1;
            check($sformatf("v%0d_ctrl", i), {60'd0, alu_ctrl}, {60'd0, vecs[i].ctrl});
            check($sformatf("v%0d_res", i), alu_result, vecs[i].res);
            check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].z});
        end

        // Store to 0x18 with a simultaneous read: old value before the edge, new after.
        @(negedge clk);
        opcode = '0;
        set_addr(64'h10, 64'h8);
        write_data = 64'hDEADBEEF; mem_write = 1'b1; mem_read = 1'b1;
        #1 check("st_addr", alu_result, 64'h18);
        check("rw_before_edge", read_data, 64'd0);
        @(posedge clk); #1;
        check("rw_after_edge", read_data, 64'hDEADBEEF);
        @(negedge clk);
        mem_write = 1'b0;
        #1 check("load", read_data, 64'hDEADBEEF);
        operand_b = 64'hC;
        #1 check("load_lowbits", read_data, 64'hDEADBEEF);
        mem_read = 1'b0;
        #1 check("read_disabled", read_data, 64'd0);
        mem_read = 1'b1;
        set_addr(64'h18 + DEPTH * 8, 64'h0);
        #1 check("load_wrap", read_data, 64'hDEADBEEF);
        set_addr(64'h20, 64'h0);
        #1 check("other_index", read_data, 64'd0);

        // Reset pulse between edges clears memory at once; writes are blocked across an edge.
        @(negedge clk);
        set_addr(64'h10, 64'h0);
        write_data = 64'h55; mem_write = 1'b1;
        @(posedge clk); #1;
        check("idx2_written", read_data, 64'h55);
        @(negedge clk);
        mem_write = 1'b0;
        #1 reset = 1'b1;
        #1 check("async_clear", read_data, 64'd0);
        set_addr(64'h18, 64'h0);
        #1 check("async_clear_18", read_data, 64'd0);
        set_addr(64'h10, 64'h0);
        write_data = 64'h77; mem_write = 1'b1;
        @(posedge clk); #1;
        check("write_blocked", read_data, 64'd0);
        @(negedge clk);
        mem_write = 1'b0; reset = 1'b0;
        #1 check("after_reset", read_data, 64'd0);
        @(posedge clk); #1;
        check("still_clear", read_data, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
